// File: rtl/gpu_pkg.sv
// Shared GPU text-mode definitions: glyph cell geometry and the glyph row payload type.
package gpu_pkg;

  localparam int unsigned GLYPH_WIDTH  = 8;
  localparam int unsigned GLYPH_HEIGHT = 8;

  typedef logic [GLYPH_WIDTH-1:0] glyph_row_t;

endpackage : gpu_pkg

// File: rtl/pixel_shift_reg.sv
// Parallel-in / serial-out glyph row serializer; data_out is the current MSB
// and selects FG (1) or BG (0) colour for the pixel being drawn.
module pixel_shift_reg
  import gpu_pkg::*;
#(
  parameter int unsigned      WIDTH     = GLYPH_WIDTH,
  parameter logic             FILL_BIT  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_enable,
  input  logic             shift_enable,
  output logic             data_out
);

  // A one-bit register has no "remaining bits" to shift, so the slice below needs WIDTH >= 2.
  if (WIDTH < 2) begin : g_bad_width
    $error("pixel_shift_reg: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] shift_q;

  // Load has priority over shift; the fill bit enters at the LSB, nothing recirculates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= RESET_VAL;
    end else if (data_in_enable) begin
      shift_q <= data_in;
    end else if (shift_enable) begin
      shift_q <= {shift_q[WIDTH-2:0], FILL_BIT};
    end
  end

  // No output flop: a freshly loaded MSB is visible in the same cycle as the load edge.
  assign data_out = shift_q[WIDTH-1];

`ifndef SYNTHESIS
  // Strobes must be resolved whenever the register is live.
  a_load_known : assert property (@(posedge clk) disable iff (rst)
    !$isunknown(data_in_enable))
    else $error("pixel_shift_reg: data_in_enable is X/Z");

  a_shift_known : assert property (@(posedge clk) disable iff (rst)
    !$isunknown(shift_enable))
    else $error("pixel_shift_reg: shift_enable is X/Z");

  a_reset_val : assert property (@(posedge clk) rst |-> (shift_q == RESET_VAL))
    else $error("pixel_shift_reg: register not at RESET_VAL during reset");
`endif

endmodule : pixel_shift_reg

// File: tb/tb_pixel_shift_reg.sv
// Directed and random checks of the glyph row serializer against hand-derived bit streams.
module tb_pixel_shift_reg;
  import gpu_pkg::*;

  logic       clk;
  logic       rst;
  glyph_row_t data_in;
  logic       data_in_enable;
  logic       shift_enable;
  logic       data_out;

  int n_checks;
  int n_fail;

  pixel_shift_reg #(.WIDTH(GLYPH_WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_enable (data_in_enable),
    .shift_enable   (shift_enable),
    .data_out       (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] model;
    logic       exp_bit;
    int         k;

    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    data_in        = '0;
    data_in_enable = 1'b0;
    shift_enable   = 1'b0;

    // Reset state
    step();
    check("reset_initial", data_out, 1'b0);
    rst = 1'b0;
    step();
    check("reset_release_idle", data_out, 1'b0);

    // Load 0xFF, then assert reset mid-cycle: output clears with no clock edge
    data_in        = 8'hFF;
    data_in_enable = 1'b1;
    step();
    check("load_ff", data_out, 1'b1);
    data_in_enable = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_mid_cycle", data_out, 1'b0);
    step();
    #4;
    rst = 1'b0;
    #1;
    check("reset_release_no_side_effect", data_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_after_reset", data_out, 1'b0);
    end

    // Load 1010_0110 then shift: 1,0,1,0,0,1,1,0 then fill zeros
    pat            = 8'b1010_0110;
    data_in        = pat;
    data_in_enable = 1'b1;
    step();
    check("load_shift_k0", data_out, 1'b1);
    data_in_enable = 1'b0;
    shift_enable   = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      exp_bit = pat[7-i];
      check("load_shift_bit", data_out, exp_bit);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check("shift_past_end_fill", data_out, 1'b0);
    end

    // Hold: 0x80 stays at 1 with no strobes, one shift drops it to 0
    shift_enable   = 1'b0;
    data_in        = 8'h80;
    data_in_enable = 1'b1;
    step();
    check("hold_load", data_out, 1'b1);
    data_in_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_idle", data_out, 1'b1);
    end
    shift_enable = 1'b1;
    step();
    check("hold_then_shift", data_out, 1'b0);
    shift_enable = 1'b0;

    // Priority: load wins over a simultaneous shift
    data_in        = 8'hF0;
    data_in_enable = 1'b1;
    step();
    check("prio_load_f0", data_out, 1'b1);
    data_in_enable = 1'b0;
    shift_enable   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("prio_shift_f0", data_out, 1'b1);
    end
    data_in        = 8'h0F;
    data_in_enable = 1'b1;
    step();
    check("prio_load_over_shift", data_out, 1'b0);
    data_in_enable = 1'b0;
    pat            = 8'h0F;
    for (int i = 1; i < 8; i++) begin
      step();
      exp_bit = pat[7-i];
      check("prio_stream_0f", data_out, exp_bit);
    end

    // Back-to-back loads: last load wins
    shift_enable   = 1'b0;
    data_in        = 8'h80;
    data_in_enable = 1'b1;
    step();
    data_in = 8'h40;
    step();
    check("b2b_last_wins_msb", data_out, 1'b0);
    data_in_enable = 1'b0;
    shift_enable   = 1'b1;
    step();
    check("b2b_last_wins_next", data_out, 1'b1);

    // GPU cadence: continuous shift, reload every 8th cycle alternating AA/55
    shift_enable = 1'b1;
    for (int i = 0; i < 640; i++) begin
      k              = i % 8;
      data_in_enable = (k == 0);
      data_in        = (((i / 8) % 2) == 0) ? 8'hAA : 8'h55;
      step();
      exp_bit = (((i / 8) % 2) == 0) ? (k % 2 == 0) : (k % 2 == 1);
      check("gpu_cadence", data_out, exp_bit);
    end
    data_in_enable = 1'b0;
    shift_enable   = 1'b0;

    // Random strobes and data against a reference model; first cycle loads to seed it
    model = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      data_in        = 8'($urandom);
      data_in_enable = (i == 0) || ($urandom_range(0, 3) == 0);
      shift_enable   = 1'($urandom_range(0, 1));
      step();
      if (data_in_enable)    model = data_in;
      else if (shift_enable) model = {model[6:0], 1'b0};
      check("random", data_out, model[7]);
    end
    data_in_enable = 1'b0;
    shift_enable   = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pixel_shift_reg
